// File: rtl/mem_port_arbiter.sv
// Two-requester (LSU, DMA) arbiter for the memory controller data port; reads hold the port two cycles.
// Optional MEM_ARB_PERF_EN adds grant/conflict performance counters.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int WID_WIDTH    = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [WID_WIDTH-1:0]  lsu_wid_i,
  input  logic [DATA_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_gnt_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_err_o,
  input  logic                  dma_req_i,
  input  logic                  dma_we_i,
  input  logic [WID_WIDTH-1:0]  dma_wid_i,
  input  logic [DATA_WIDTH-1:0] dma_addr_i,
  input  logic [DATA_WIDTH-1:0] dma_wdata_i,
  output logic                  dma_gnt_o,
  output logic                  dma_rvalid_o,
  output logic [DATA_WIDTH-1:0] dma_rdata_o,
  output logic                  dma_err_o,
  output logic                  mem_en_o,
  output logic                  mem_enwr_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [WID_WIDTH-1:0]  mem_wid_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_unalign_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_lsu_o,
  output logic [31:0]           perf_dma_o,
  output logic [31:0]           perf_conflict_o
`endif
);

  typedef enum logic {IDLE, RD_HOLD} state_t;

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t                  state_reg;
  logic [SW-1:0]           starve_reg;
  logic                    cmd_owner_reg;  // 1 = DMA owns the latched command
  logic                    cmd_we_reg;
  logic [DATA_WIDTH-1:0]   cmd_addr_reg;
  logic [WID_WIDTH-1:0]    cmd_wid_reg;
  logic [DATA_WIDTH-1:0]   cmd_wdata_reg;
  logic                    err_pend_reg;

  logic                    idle;
  logic                    starved;
  logic                    pick_dma;
  logic                    pick_lsu;
  logic                    granted;
  logic                    sel_we;
  logic [WID_WIDTH-1:0]    sel_wid;
  logic [DATA_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  always_comb begin
    idle      = (state_reg == IDLE) && !rst;
    starved   = (STARVE_LIMIT != 0) && (starve_reg == STARVE_MAX);
    pick_dma  = idle && dma_req_i && (starved || !lsu_req_i);
    pick_lsu  = idle && lsu_req_i && !pick_dma;
    granted   = pick_dma || pick_lsu;
    sel_we    = pick_dma ? dma_we_i    : lsu_we_i;
    sel_wid   = pick_dma ? dma_wid_i   : lsu_wid_i;
    sel_addr  = pick_dma ? dma_addr_i  : lsu_addr_i;
    sel_wdata = pick_dma ? dma_wdata_i : lsu_wdata_i;
    lsu_gnt_o = pick_lsu;
    dma_gnt_o = pick_dma;

    // Idle port keeps showing the last command so the controller sees no spurious changes
    mem_en_o    = 1'b0;
    mem_enwr_o  = !cmd_we_reg;
    mem_addr_o  = cmd_addr_reg;
    mem_wid_o   = cmd_wid_reg;
    mem_wdata_o = cmd_wdata_reg;
    if (granted) begin
      mem_en_o    = 1'b1;
      mem_enwr_o  = !sel_we;
      mem_addr_o  = sel_addr;
      mem_wid_o   = sel_wid;
      mem_wdata_o = sel_wdata;
    end else if (state_reg == RD_HOLD && !rst) begin
      mem_en_o   = 1'b1;
      mem_enwr_o = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      starve_reg    <= '0;
      cmd_owner_reg <= 1'b0;
      cmd_we_reg    <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_wid_reg   <= '0;
      cmd_wdata_reg <= '0;
      err_pend_reg  <= 1'b0;
      lsu_rvalid_o  <= 1'b0;
      lsu_rdata_o   <= '0;
      lsu_err_o     <= 1'b0;
      dma_rvalid_o  <= 1'b0;
      dma_rdata_o   <= '0;
      dma_err_o     <= 1'b0;
    end else begin
      lsu_rvalid_o <= 1'b0;
      lsu_rdata_o  <= '0;
      lsu_err_o    <= 1'b0;
      dma_rvalid_o <= 1'b0;
      dma_rdata_o  <= '0;
      dma_err_o    <= 1'b0;

      if (!dma_req_i || pick_dma)
        starve_reg <= '0;
      else if (starve_reg != STARVE_MAX)
        starve_reg <= starve_reg + SW'(1);

      case (state_reg)
        IDLE: begin
          if (granted) begin
            cmd_owner_reg <= pick_dma;
            cmd_we_reg    <= sel_we;
            cmd_addr_reg  <= sel_addr;
            cmd_wid_reg   <= sel_wid;
            cmd_wdata_reg <= sel_wdata;
            err_pend_reg  <= mem_unalign_i;
            if (sel_we) begin
              if (pick_dma) begin
                dma_rvalid_o <= 1'b1;
                dma_err_o    <= mem_unalign_i;
              end else begin
                lsu_rvalid_o <= 1'b1;
                lsu_err_o    <= mem_unalign_i;
              end
            end else begin
              state_reg <= RD_HOLD;
            end
          end
        end
        RD_HOLD: begin
          state_reg <= IDLE;
          if (cmd_owner_reg) begin
            dma_rvalid_o <= 1'b1;
            dma_rdata_o  <= mem_rdata_i;
            dma_err_o    <= err_pend_reg;
          end else begin
            lsu_rvalid_o <= 1'b1;
            lsu_rdata_o  <= mem_rdata_i;
            lsu_err_o    <= err_pend_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  // A cycle with both requests high always denies at least one of them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lsu_o      <= '0;
      perf_dma_o      <= '0;
      perf_conflict_o <= '0;
    end else begin
      if (pick_lsu)
        perf_lsu_o <= perf_lsu_o + 32'd1;
      if (pick_dma)
        perf_dma_o <= perf_dma_o + 32'd1;
      if (lsu_req_i && dma_req_i)
        perf_conflict_o <= perf_conflict_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small behavioural memory controller.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_we, dma_req, dma_we;
  logic [2:0]  lsu_wid, dma_wid;
  logic [63:0] lsu_addr, lsu_wdata, dma_addr, dma_wdata;
  logic        lsu_gnt, lsu_rvalid, lsu_err, dma_gnt, dma_rvalid, dma_err;
  logic [63:0] lsu_rdata, dma_rdata;
  logic        mem_en, mem_enwr, mem_unalign;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_wid;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_lsu, perf_dma, perf_conflict;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mem_model [16];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_wid_i(lsu_wid),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_gnt_o(lsu_gnt), .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata), .lsu_err_o(lsu_err),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_wid_i(dma_wid),
    .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid), .dma_rdata_o(dma_rdata), .dma_err_o(dma_err),
    .mem_en_o(mem_en), .mem_enwr_o(mem_enwr), .mem_addr_o(mem_addr),
    .mem_wid_o(mem_wid), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_unalign_i(mem_unalign)
`ifdef MEM_ARB_PERF_EN
    , .perf_lsu_o(perf_lsu), .perf_dma_o(perf_dma), .perf_conflict_o(perf_conflict)
`endif
  );

  function automatic logic misaligned(input logic [2:0] w, input logic [63:0] a);
    if (w == 3'd7) return 1'b1;
    case (w[1:0])
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return |a[2:0];
    endcase
  endfunction

  // Controller model: decodes from the currently driven command, stores writes at the clock edge
  assign mem_unalign = mem_en && misaligned(mem_wid, mem_addr);
  assign mem_rdata   = (mem_en && mem_enwr) ? mem_model[mem_addr[6:3]] : 64'd0;

  always @(posedge clk)
    if (mem_en && !mem_enwr) mem_model[mem_addr[6:3]] <= mem_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    lsu_req = 0; lsu_we = 0; lsu_wid = 0; lsu_addr = 0; lsu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_wid = 0; dma_addr = 0; dma_wdata = 0;
    #2;
    chk("rst_lsu_gnt", lsu_gnt, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_lsu_rvalid", lsu_rvalid, 0);
    chk("rst_dma_rvalid", dma_rvalid, 0);
    chk("rst_lsu_rdata", lsu_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_enwr", mem_enwr, 1);
    chk("rst_mem_addr", mem_addr, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // LSU write
    cyc();
    lsu_req = 1; lsu_we = 1; lsu_addr = 64'h10; lsu_wid = 3; lsu_wdata = 64'h1122334455667788;
    #1;
    chk("wr_gnt", lsu_gnt, 1);
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_enwr", mem_enwr, 0);
    chk("wr_mem_wdata", mem_wdata, 64'h1122334455667788);
    cyc();
    lsu_req = 0;
    #1;
    chk("wr_rvalid", lsu_rvalid, 1);
    chk("wr_err", lsu_err, 0);
    chk("wr_rdata", lsu_rdata, 0);
    chk("wr_dma_rvalid", dma_rvalid, 0);
    chk("wr_idle_en", mem_en, 0);
    chk("wr_idle_addr_hold", mem_addr, 64'h10);

    // LSU read, request kept high to show the earliest re-grant
    cyc();
    lsu_req = 1; lsu_we = 0;
    #1;
    chk("rd_gnt", lsu_gnt, 1);
    chk("rd_addr_n", mem_addr, 64'h10);
    chk("rd_enwr_n", mem_enwr, 1);
    cyc();
    #1;
    chk("rd_hold_gnt", lsu_gnt, 0);
    chk("rd_hold_en", mem_en, 1);
    chk("rd_hold_addr", mem_addr, 64'h10);
    chk("rd_hold_rvalid", lsu_rvalid, 0);
    cyc();
    #1;
    chk("rd_rvalid", lsu_rvalid, 1);
    chk("rd_rdata", lsu_rdata, 64'h1122334455667788);
    chk("rd_regrant", lsu_gnt, 1);
    cyc();
    lsu_req = 0;
    #1;
    cyc();
    #1;
    chk("rd2_rvalid", lsu_rvalid, 1);
    chk("rd2_rdata", lsu_rdata, 64'h1122334455667788);

    // Starvation: LSU reads back to back, DMA write waits for 8 denied cycles
    cyc();
    lsu_req = 1; lsu_we = 0; lsu_addr = 64'h10; lsu_wid = 3;
    dma_req = 1; dma_we = 1; dma_addr = 64'h20; dma_wid = 3; dma_wdata = 64'hA5A5;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) cyc();
      if (c == 9) dma_wdata = 64'h5A5A;
      #1;
      chk($sformatf("starve_dma_gnt_c%0d", c), dma_gnt, (c == 8) ? 64'd1 : 64'd0);
      chk($sformatf("starve_lsu_gnt_c%0d", c), lsu_gnt,
          (((c % 2) == 0 && c < 8) || c == 9) ? 64'd1 : 64'd0);
      chk($sformatf("starve_lsu_rvalid_c%0d", c), lsu_rvalid,
          ((c % 2) == 0 && c >= 2 && c <= 8) ? 64'd1 : 64'd0);
      chk($sformatf("starve_dma_rvalid_c%0d", c), dma_rvalid, (c == 9) ? 64'd1 : 64'd0);
    end
    cyc();
    lsu_req = 0; dma_req = 0;
    #1;
    chk("starve_tail_hold_en", mem_en, 1);
    cyc();
    #1;
    chk("starve_tail_rvalid", lsu_rvalid, 1);

    // Unaligned LSU word write
    cyc();
    lsu_req = 1; lsu_we = 1; lsu_wid = 2; lsu_addr = 64'h13;
    #1;
    chk("unal_gnt", lsu_gnt, 1);
    cyc();
    lsu_req = 0;
    #1;
    chk("unal_rvalid", lsu_rvalid, 1);
    chk("unal_err", lsu_err, 1);
    chk("unal_dma_rvalid", dma_rvalid, 0);

    // Illegal width DMA read
    cyc();
    dma_req = 1; dma_we = 0; dma_wid = 7; dma_addr = 64'h10;
    #1;
    chk("ill_gnt", dma_gnt, 1);
    chk("ill_mem_wid", mem_wid, 7);
    cyc();
    dma_req = 0;
    #1;
    chk("ill_hold_rvalid", dma_rvalid, 0);
    cyc();
    #1;
    chk("ill_rvalid", dma_rvalid, 1);
    chk("ill_err", dma_err, 1);
    chk("ill_lsu_rvalid", lsu_rvalid, 0);
    chk("ill_lsu_rdata", lsu_rdata, 0);

    // Reset in the middle of a DMA read
    cyc();
    dma_req = 1; dma_we = 0; dma_wid = 3; dma_addr = 64'h10;
    #1;
    chk("rstrd_gnt", dma_gnt, 1);
    cyc();
    dma_req = 0;
    #1;
    chk("rstrd_hold_en", mem_en, 1);
    rst = 1'b1;
    #1;
    chk("rstrd_en_now", mem_en, 0);
    chk("rstrd_enwr_now", mem_enwr, 1);
    #1;
    rst = 1'b0;
    cyc();
    #1;
    chk("rstrd_no_rvalid", dma_rvalid, 0);
    chk("rstrd_idle_en", mem_en, 0);

`ifdef MEM_ARB_PERF_EN
    rst = 1'b1;
    #1;
    rst = 1'b0;
    cyc();
    lsu_req = 1; lsu_we = 0; lsu_wid = 3; lsu_addr = 64'h8;
    dma_req = 1; dma_we = 1; dma_wid = 3; dma_addr = 64'h18;
    #1;
    cyc();
    lsu_we = 1;
    #1;
    cyc();
    #1;
    cyc();
    lsu_addr = 64'h28;
    #1;
    cyc();
    lsu_req = 0;
    #1;
    cyc();
    dma_addr = 64'h38;
    #1;
    cyc();
    dma_req = 0;
    #1;
    chk("perf_lsu", perf_lsu, 3);
    chk("perf_dma", perf_dma, 2);
    chk("perf_conflict", perf_conflict, 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data port of the core's memory controller between two requesters: the pipeline LSU (port 0) and the boot/debug DMA loader (port 1).
- The RAM read is synchronous, and the controller decodes read data using the address and width it is currently being driven with. The block therefore holds each read command stable for two cycles.
- Per-requester valid/grant handshake; registered responses routed back to the request's owner.
- Fixed LSU priority, with an anti-starvation override for the DMA port.

Parameters:
DATA_WIDTH, 64, data and address width.
WID_WIDTH, 3, access-width code width (B=0, H=1, W=2, D=3, BU=4, HU=5, WU=6).
STARVE_LIMIT, 8, consecutive denied DMA-request cycles before DMA is forced ahead of the LSU; 0 disables the override.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
lsu_req_i  in  1  LSU request valid; held until granted
lsu_we_i  in  1  1=write, 0=read
lsu_wid_i  in  WID_WIDTH  access width code
lsu_addr_i  in  DATA_WIDTH  byte address
lsu_wdata_i  in  DATA_WIDTH  write data
lsu_gnt_o  out  1  request accepted this cycle
lsu_rvalid_o  out  1  response pulse
lsu_rdata_o  out  DATA_WIDTH  read data (0 for writes)
lsu_err_o  out  1  unaligned/illegal access, valid with rvalid
dma_req_i, dma_we_i, dma_wid_i, dma_addr_i, dma_wdata_i  in  as LSU  DMA request
dma_gnt_o, dma_rvalid_o, dma_rdata_o, dma_err_o  out  as LSU  DMA response
mem_en_o  out  1  controller enable
mem_enwr_o  out  1  0=write, 1=read (controller encoding)
mem_addr_o  out  DATA_WIDTH  address to controller
mem_wid_o  out  WID_WIDTH  width code to controller
mem_wdata_o  out  DATA_WIDTH  write data to controller
mem_rdata_i  in  DATA_WIDTH  decoded read data from controller
mem_unalign_i  in  1  controller unaligned-access flag

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, starve counter 0.
  - All gnt, rvalid and err outputs 0; rdata outputs 0.
  - mem_en_o=0, mem_enwr_o=1, mem_addr_o/mem_wid_o/mem_wdata_o=0.
- FSM has two states: IDLE and RD_HOLD.
- IDLE, arbitration:
  - Winner = DMA if dma_req_i && (starve==STARVE_LIMIT, STARVE_LIMIT≠0 || !lsu_req_i); else LSU if lsu_req_i.
  - Winner's gnt_o=1 combinationally, same cycle. mem_* are driven combinationally from the winner's inputs with mem_en_o=1 and mem_enwr_o=!we.
  - Command (owner, addr, wid, we) is latched.
  - No request: mem_en_o=0, other mem_* hold the last command.
- Write grant at cycle N:
  - Stay in IDLE, so back-to-back writes are allowed every cycle.
  - Owner rvalid=1 at N+1, rdata=0, err=mem_unalign_i sampled at N.
- Read grant at cycle N:
  - Go to RD_HOLD at N+1. During RD_HOLD, mem_* are driven from the latched command (mem_en_o=1, mem_enwr_o=1) and both gnt=0.
  - At the end of N+1, register mem_rdata_i.
  - Owner rvalid=1, rdata, err (mem_unalign_i sampled at N) at N+2; return to IDLE at N+2.
  - A read therefore occupies the port 2 cycles; the next grant is possible at N+2.
- Handshake:
  - Requesters keep req and payload stable until gnt. The block never drops a pending request.
  - rvalid is a 1-cycle pulse with no back-pressure. Exactly one response per grant.
  - The response goes only to the owner port; the other port's rvalid=0 and rdata=0.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle dma_req_i=1 && !dma_gnt_o.
  - Clears on dma_gnt_o, or when dma_req_i=0.
  - RD_HOLD cycles also count.
- Illegal wid (7): forwarded unchanged; the controller flags it, and err=1 is reported on the response.
- Reset mid-read (in RD_HOLD): immediate return to IDLE; the pending response is discarded and never emitted.
- Both requests simultaneously with the counter below the limit: LSU wins and DMA waits.

Optional Feature:
- MEM_ARB_PERF_EN defined:
  - Adds outputs perf_lsu_o[31:0], perf_dma_o[31:0] and perf_conflict_o[31:0].
  - Counts LSU grants, DMA grants, and cycles in which both req were high with at least one denied.
  - Counters wrap at 2^32 and clear on rst.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- LSU write only: addr=0x10, wid=3, wdata=0x1122334455667788 at N → lsu_gnt_o=1 at N; mem_en_o=1, mem_enwr_o=0 at N; lsu_rvalid_o=1, err=0 at N+1.
- LSU read only: addr=0x10, wid=3 at N → mem_addr_o=0x10 held N and N+1; lsu_rvalid_o at N+2, lsu_rdata_o=0x1122334455667788; next grant earliest at N+2.
- Simultaneous requests, STARVE_LIMIT=8, LSU reads continuously and DMA requests a write → DMA denied until the counter reaches 8; dma_gnt_o then asserts ahead of a pending LSU request; counter returns to 0.
- LSU write wid=2, addr=0x13 with mem_unalign_i=1 → lsu_rvalid_o=1 and lsu_err_o=1 at N+1; dma_rvalid_o stays 0.
- DMA read granted at N, rst asserted at N+1 → state IDLE, mem_en_o=0 immediately; no dma_rvalid_o at N+2.
- With MEM_ARB_PERF_EN: 3 LSU grants, 2 DMA grants, 4 conflict cycles → perf_lsu_o=3, perf_dma_o=2, perf_conflict_o=4.
